nonce_dispatcher: RTL
=====================

# nonce_dispatcher

Schedules a fixed nonce range across `NUM_CORES` parallel bitcoin hash cores and serialises their results onto the single shared memory write port. It sits between the top-level start/done handshake and the hash core array. It issues each core a nonce with a start pulse, captures each core's final `h0` word, and writes that word to `output_addr + nonce`. It redispatches each freed core until all `NONCES` results are stored.

## Interface
- `NUM_CORES`, default 4: number of hash cores, 1..16.
- `NONCES`, default 16: nonces per job, 1..65535. Nonces run 0..NONCES-1.
- `clk` input, 1 bit: single clock. All logic is on the rising edge.
- `reset_n` input, 1 bit: asynchronous active-low reset.
- `start` input, 1 bit: job request. Sampled only in IDLE.
- `output_addr` input, 16 bits: result base address. Captured on an accepted `start`.
- `done` output, 1 bit: one-cycle pulse when the last result has been written.
- `busy` output, 1 bit: high from the cycle after an accepted `start` through the `done` cycle.
- `err` output, 1 bit: sticky protocol-violation flag. Cleared only by reset or an accepted `start`.
- `core_start` output, NUM_CORES bits: one-cycle start pulse per core.
- `core_nonce` output, NUM_CORES*32 bits: per-core nonce, slice i = [32i+31:32i]. Held stable from the `core_start` pulse until the next `core_start` to that core.
- `core_done` input, NUM_CORES bits: one-cycle completion pulse per core.
- `core_hash` input, NUM_CORES*32 bits: per-core final `h0`. Valid in the `core_done` cycle.
- `mem_we` output, 1 bit: memory write enable.
- `mem_addr` output, 16 bits: write address.
- `mem_write_data` output, 32 bits: write data.

## Operation
- States:
  - IDLE -> RUN on `start`.
  - RUN -> DONE when the written count reaches NONCES.
  - DONE -> IDLE unconditionally.
- Per-core state, encoded as {busy_i, pend_i}:
  - FREE: 0/0.
  - COMPUTING: 1/0.
  - PENDING: 0/1, holding captured `res_i[31:0]` and `nonce_i[15:0]`.
- Accepting `start` in IDLE:
  - latch `output_addr`;
  - clear `next_nonce`, `written`, `err` and the round-robin pointer `rr`;
  - set all cores FREE.
- Dispatch, every RUN cycle: each FREE core i with `next_nonce + (rank of i among FREE cores) < NONCES` is handled as follows.
  - Assert `core_start[i]` for that cycle.
  - Drive `core_nonce[i]` with its assigned nonce.
  - Move core i to COMPUTING.
  - Advance `next_nonce` by the number of cores dispatched.
  - Rank runs in ascending core index, so the lowest index takes the lowest nonce.
- Capture: `core_done[i]` while core i is COMPUTING stores `core_hash` slice i into `res_i` and moves core i to PENDING.
- Write arbitration:
  - Each RUN cycle, select the first PENDING core at or after `rr`, searching cyclically.
  - Drive `mem_we=1`, `mem_addr = base + nonce_i` (mod 2^16, wraps silently), `mem_write_data = res_i`.
  - Core i moves to FREE; it is eligible for dispatch the following cycle, not the same one.
  - Set `rr = i+1` mod NUM_CORES and increment `written`.
  - At most one write per cycle.
- Completion: when `written` reaches NONCES after a write, the next cycle is DONE, with `done=1`, `busy=1`, `mem_we=0`.
- Violations, each setting `err`:
  - `core_done[i]` while core i is not COMPUTING. The pulse is otherwise ignored; `res_i` is unchanged.
  - `start` in RUN or DONE. It is otherwise ignored.
- Arithmetic:
  - `next_nonce` and `written` are 17 bits; nonces on `core_nonce` are zero-extended to 32 bits.
  - No nonce is ever issued twice, and none ≥ NONCES is issued.

## Timing
- Reset (asynchronous): state IDLE. `done`, `busy`, `err`, `core_start`, `mem_we` = 0; `core_nonce`, `mem_addr`, `mem_write_data` = 0. All cores FREE.
- Reset mid-job aborts immediately. No further `core_start` or `mem_we` until a new `start`. Cores already running must be reset by the same `reset_n`.
- `start` high at edge T: `busy=1` from T+1. The first `core_start` pulses cover cores 0..min(NUM_CORES,NONCES)-1 in cycle T+1.
- `core_done[i]` at edge T: `mem_we` for that result at the earliest in cycle T+1; later if other PENDING cores win arbitration. Earliest redispatch of core i is cycle T+2.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- `done` is high for exactly one cycle, followed by IDLE. A `start` in the `done` cycle is an error; a `start` in the first IDLE cycle after it is accepted.

## Test plan
- Defaults, cores modelled with a fixed 10-cycle latency and `hash = nonce*0x01010101`, `output_addr=0x0100`: 16 writes to 0x0100..0x010F with matching data, each address exactly once. One `done` pulse. `err=0`.
- NUM_CORES=4, NONCES=3: only `core_start[2:0]` pulse, with nonces 0,1,2. `core_start[3]` never pulses. Exactly 3 writes, then `done`.
- All four cores assert `core_done` in the same cycle T: writes occur in cycles T+1..T+4 in order 0,1,2,3 (rr=0). Each core redispatches one cycle after its own write, with nonces 4,5,6,7.
- `output_addr=0xFFFE`, NONCES=4: writes go to 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Spurious `core_done[1]` while core 1 is FREE: `err=1` and stays set. No extra write. The job still completes with 16 correct writes.
- `reset_n` pulled low mid-RUN after 5 writes: all outputs are 0 immediately. A new `start` reruns nonces 0..15 correctly.

Source files
------------

// File: rtl/nonce_dispatcher.sv
// nonce_dispatcher: hands out nonces 0..NONCES-1 to a bank of hash cores,
// collects each core's final h0 word and serialises the results onto one
// memory write port at output_addr + nonce.
module nonce_dispatcher #(
    parameter int NUM_CORES = 4,
    parameter int NONCES    = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [15:0]               output_addr,
    output logic                      done,
    output logic                      busy,
    output logic                      err,
    output logic [NUM_CORES-1:0]      core_start,
    output logic [NUM_CORES*32-1:0]   core_nonce,
    input  logic [NUM_CORES-1:0]      core_done,
    input  logic [NUM_CORES*32-1:0]   core_hash,
    output logic                      mem_we,
    output logic [15:0]               mem_addr,
    output logic [31:0]               mem_write_data
);

    localparam int          RR_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [16:0] NONCES_L = 17'(NONCES);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t                 state, state_nx;
    logic [15:0]            base;
    logic [16:0]            next_nonce;
    logic [16:0]            written;
    logic [RR_W-1:0]        rr;

    // Per-core status: {cbusy, pend} = 00 free, 10 computing, 01 pending.
    logic [NUM_CORES-1:0]   cbusy;
    logic [NUM_CORES-1:0]   pend;
    logic [31:0]            res [NUM_CORES];

    logic                   accept;
    logic                   spurious;
    logic [NUM_CORES-1:0]   cap;
    logic [NUM_CORES-1:0]   free_eff;
    logic [16:0]            base_nonce;
    logic [NUM_CORES-1:0]   disp;
    logic [16:0]            disp_nonce [NUM_CORES];
    logic [16:0]            disp_cnt;

    logic [NUM_CORES-1:0]   pend_eff;
    logic                   wr_hit;
    logic [NUM_CORES-1:0]   wr_sel;
    logic [RR_W-1:0]        wr_rr_nx;
    logic [RR_W-1:0]        idx;
    logic [15:0]            wr_addr;
    logic [31:0]            wr_data;

    assign accept   = (state == IDLE) && start;
    assign cap      = core_done & cbusy;
    assign spurious = |(core_done & ~cbusy);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next-state: a job runs until every result has been written.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (written == NONCES_L) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Dispatch: free cores take consecutive nonces in ascending core order.
    // The accepting edge itself dispatches with every core free from nonce 0.
    always_comb begin
        free_eff   = '0;
        base_nonce = '0;
        disp       = '0;
        disp_cnt   = '0;
        for (int i = 0; i < NUM_CORES; i++) disp_nonce[i] = '0;
        if (accept) begin
            free_eff   = '1;
            base_nonce = '0;
        end else if (state == RUN) begin
            free_eff   = ~cbusy & ~pend;
            base_nonce = next_nonce;
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            if (free_eff[i] && ((base_nonce + disp_cnt) < NONCES_L)) begin
                disp[i]       = 1'b1;
                disp_nonce[i] = base_nonce + disp_cnt;
                disp_cnt      = disp_cnt + 17'd1;
            end
        end
    end

    // Write arbitration: first pending core at or after rr, cyclically. A core
    // finishing this cycle competes directly so its result can go out next cycle.
    always_comb begin
        pend_eff = (state == RUN) ? (pend | cap) : '0;
        wr_hit   = 1'b0;
        wr_sel   = '0;
        wr_rr_nx = '0;
        wr_addr  = '0;
        wr_data  = '0;
        idx      = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx = RR_W'((int'(rr) + k) % NUM_CORES);
            if (!wr_hit && pend_eff[idx]) begin
                wr_hit      = 1'b1;
                wr_sel[idx] = 1'b1;
                wr_rr_nx    = RR_W'((int'(idx) + 1) % NUM_CORES);
                wr_addr     = base + core_nonce[{idx, 5'd0} +: 16];
                wr_data     = pend[idx] ? res[idx] : core_hash[{idx, 5'd0} +: 32];
            end
        end
    end

    // Job bookkeeping: base address, nonce/write counters, rr pointer, err flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base       <= '0;
            next_nonce <= '0;
            written    <= '0;
            rr         <= '0;
            err        <= 1'b0;
        end else if (accept) begin
            base       <= output_addr;
            next_nonce <= disp_cnt;
            written    <= '0;
            rr         <= '0;
            err        <= 1'b0;
        end else begin
            err <= err | spurious | start;
            if (state == RUN) begin
                next_nonce <= next_nonce + disp_cnt;
                if (wr_hit) begin
                    written <= written + 17'd1;
                    rr      <= wr_rr_nx;
                end
            end
        end
    end

    // Per-core status, start pulses, issued nonces and captured results.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cbusy      <= '0;
            pend       <= '0;
            core_start <= '0;
            core_nonce <= '0;
            for (int i = 0; i < NUM_CORES; i++) res[i] <= '0;
        end else begin
            core_start <= disp;
            for (int i = 0; i < NUM_CORES; i++) begin
                if (disp[i]) begin
                    cbusy[i]              <= 1'b1;
                    pend[i]               <= 1'b0;
                    core_nonce[i*32 +: 32] <= {15'd0, disp_nonce[i]};
                end else if (accept || wr_sel[i]) begin
                    cbusy[i] <= 1'b0;
                    pend[i]  <= 1'b0;
                end else if (cap[i]) begin
                    cbusy[i] <= 1'b0;
                    pend[i]  <= 1'b1;
                    res[i]   <= core_hash[i*32 +: 32];
                end
            end
        end
    end

    // Registered handshake and memory port outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done           <= 1'b0;
            busy           <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
        end else begin
            done   <= (state == RUN) && (written == NONCES_L);
            busy   <= (state_nx != IDLE);
            mem_we <= wr_hit;
            if (wr_hit) begin
                mem_addr       <= wr_addr;
                mem_write_data <= wr_data;
            end
        end
    end

endmodule
